// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state encoding, default sizing and counter width helper for the port arbiter
package mem_port_arbiter_pkg;
    localparam int DEF_M = 4;
    localparam int DEF_N = 2;
    localparam int DEF_TO_CYCLES = 15;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
    function automatic int cnt_width(input int limit);
        return $clog2(limit + 1);
    endfunction
endpackage

// File: rtl/mem_port_arbiter_rr_priority_pick.sv
// rr_priority_pick: combinational round-robin winner search starting at ptr and wrapping at M-1
module rr_priority_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int M = DEF_M,
    parameter int N = DEF_N
) (
    input  logic [M-1:0] req,
    input  logic [N-1:0] ptr,
    output logic         any,
    output logic [N-1:0] win_idx
);
    logic [M-1:0] hi;
    logic [N-1:0] win_hi;
    logic [N-1:0] win_lo;
    // hi holds requests at or above ptr; fall back to the lowest request overall when none
    always_comb begin
        hi = '0;
        win_hi = '0;
        win_lo = '0;
        for (int j = M - 1; j >= 0; j--) begin
            hi[j] = req[j] && (j >= int'(ptr));
            if (hi[j]) win_hi = N'(j);
            if (req[j]) win_lo = N'(j);
        end
    end
    assign any = |req;
    assign win_idx = |hi ? win_hi : win_lo;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin shared memory port arbiter, grant held until done; optional watchdog under ARB_TIMEOUT_EN
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int M = DEF_M,
    parameter int N = DEF_N,
    parameter int TO_CYCLES = DEF_TO_CYCLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [M-1:0] req,
    input  logic         done,
    output logic [M-1:0] gnt,
    output logic [N-1:0] gnt_idx,
    output logic         gnt_valid,
    output logic         timeout
);
    state_t state, state_nxt;
    logic [N-1:0] ptr, ptr_arb, idx_inc, win_idx, gnt_idx_nxt;
    logic [M-1:0] gnt_nxt;
    logic any, to_hit, rel, load;
    assign idx_inc = (gnt_idx == N'(M - 1)) ? '0 : gnt_idx + 1'b1;
    assign rel = (state == BUSY) && (done || to_hit);
    assign load = (state == IDLE) || rel;
    // on release the just-served requester drops to lowest priority in the same cycle
    assign ptr_arb = rel ? idx_inc : ptr;
    rr_priority_pick #(.M(M), .N(N)) u_pick (
        .req(req),
        .ptr(ptr_arb),
        .any(any),
        .win_idx(win_idx)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr <= '0;
            gnt <= '0;
            gnt_idx <= '0;
            gnt_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            gnt <= gnt_nxt;
            gnt_idx <= gnt_idx_nxt;
            gnt_valid <= |gnt_nxt;
            if (rel) ptr <= ptr_arb;
        end
    end
    always_comb state_nxt = load ? (any ? BUSY : IDLE) : state;
    always_comb begin
        gnt_nxt = load ? (any ? M'(1) << win_idx : '0) : gnt;
        gnt_idx_nxt = load ? (any ? win_idx : '0) : gnt_idx;
    end
`ifdef ARB_TIMEOUT_EN
    localparam int CW = cnt_width(TO_CYCLES);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (load && any) cnt <= '0;
        else if (state == BUSY && !done) cnt <= cnt + 1'b1;
    end
    // a coincident done wins, so the watchdog only fires when done is absent
    assign to_hit = (state == BUSY) && !done && (cnt == CW'(TO_CYCLES));
    assign timeout = to_hit;
`else
    assign to_hit = 1'b0;
    assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter (M=4) plus a wrap instance (M=3)
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] req = '0;
    logic done = 1'b0;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic gnt_valid, timeout;
    logic [2:0] req3 = '0;
    logic done3 = 1'b0;
    logic [2:0] gnt3;
    logic [1:0] gnt_idx3;
    logic gnt_valid3, timeout3;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    mem_port_arbiter #(.M(4), .N(2), .TO_CYCLES(15)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
    );
    mem_port_arbiter #(.M(3), .N(2), .TO_CYCLES(15)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req(req3), .done(done3),
        .gnt(gnt3), .gnt_idx(gnt_idx3), .gnt_valid(gnt_valid3), .timeout(timeout3)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic grant_is(input string tag, input int idx);
        check({tag, "_gnt"}, gnt, 32'(1) << idx);
        check({tag, "_idx"}, gnt_idx, idx);
        check({tag, "_valid"}, gnt_valid, 1);
    endtask
    task automatic idle_is(input string tag);
        check({tag, "_gnt"}, gnt, 0);
        check({tag, "_idx"}, gnt_idx, 0);
        check({tag, "_valid"}, gnt_valid, 0);
    endtask
    initial begin
        int seq[6] = '{0, 1, 2, 3, 0, 1};
        int seq3[3] = '{1, 2, 0};
        step(3);
        idle_is("reset");
        check("reset_to", timeout, 0);
        rst_n = 1'b1;
        req = 4'b0100;
        step(1);
        grant_is("single", 2);
        req = 4'b0000;
        step(2);
        done = 1'b1;
        step(1);
        done = 1'b0;
        idle_is("single_rel");
        req = 4'b1111;
        step(1);
        grant_is("after_single", 3);
        foreach (seq[k]) begin
            step(1);
            check("fair_hold", gnt_valid, 1);
            step(1);
            done = 1'b1;
            step(1);
            done = 1'b0;
            grant_is($sformatf("fair%0d", k), seq[k]);
        end
        req = 4'b0000;
        step(3);
        grant_is("drop_held", 1);
        done = 1'b1;
        step(1);
        done = 1'b0;
        idle_is("drop_rel");
        done = 1'b1;
        step(1);
        done = 1'b0;
        idle_is("spurious");
        req = 4'b1111;
        step(1);
        grant_is("ptr_kept", 2);
        done = 1'b1;
        step(1);
        done = 1'b0;
        grant_is("next3", 3);
        #2 rst_n = 1'b0;
        #1 idle_is("async_rst");
        step(1);
        idle_is("rst_held");
        rst_n = 1'b1;
        step(1);
        grant_is("post_rst", 0);
`ifdef ARB_TIMEOUT_EN
        req = 4'b0011;
        step(14);
        check("to_early", timeout, 0);
        step(1);
        check("to_pulse", timeout, 1);
        check("to_idx_held", gnt_idx, 0);
        step(1);
        check("to_clear", timeout, 0);
        grant_is("to_next", 1);
        step(15);
        done = 1'b1;
        #1 check("to_done_wins", timeout, 0);
        step(1);
        done = 1'b0;
        check("to_after_done", timeout, 0);
        grant_is("to_done_next", 0);
`else
        step(20);
        check("no_to", timeout, 0);
        grant_is("held_forever", 0);
`endif
        req3 = 3'b111;
        step(1);
        check("wrap_first", gnt_idx3, 0);
        check("wrap_first_gnt", gnt3, 3'b001);
        foreach (seq3[k]) begin
            step(1);
            done3 = 1'b1;
            step(1);
            done3 = 1'b0;
            check($sformatf("wrap%0d", k), gnt_idx3, seq3[k]);
            check($sformatf("wrap%0d_gnt", k), gnt3, 32'(1) << seq3[k]);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
